// File: rtl/io_bridge_pkg.sv
// Shared types and constants for the load/store IO bridge.
package io_bridge_pkg;

  localparam int          IO_TIMEOUT_W        = 16;
  localparam logic [31:0] IO_ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  wstrb;
  } io_req_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [3:0]  be;
    logic        store;
    logic        load;
  } data_access_shared_inputs_t;

endpackage

// File: rtl/io_bridge_if.sv
// Handshake between the load/store unit and one of its sub-units.
interface ls_sub_unit_interface;
  logic ready;
  logic new_request;
  logic data_valid;

  modport sub_unit (output ready, output data_valid, input new_request);
  modport unit     (input ready, input data_valid, output new_request);
endinterface

// File: rtl/io_bridge_hold.sv
// Single-entry valid/ready holding register for one bus request.
module io_req_hold
  import io_bridge_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    load_en,
  input  io_req_t load_req,
  input  logic    out_ready,
  output logic    out_valid,
  output io_req_t out_req
);

  logic    valid_q, valid_d;
  io_req_t req_q, req_d;

  // load_en is only raised by the parent while the entry is empty
  always_comb begin
    valid_d = valid_q;
    req_d   = req_q;
    if (valid_q && out_ready) valid_d = 1'b0;
    if (load_en) begin
      valid_d = 1'b1;
      req_d   = load_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      req_q   <= '0;
    end else begin
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

  assign out_valid = valid_q;
  assign out_req   = req_q;

endmodule

// File: rtl/io_bridge.sv
// IO load/store sub-unit: held request, in-order outstanding reads,
// posted writes and a per-read response timeout.
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          TIMEOUT_CYCLES  = 255,
  parameter logic [31:0] ERR_DATA        = IO_ERR_DATA_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  data_access_shared_inputs_t ls_inputs,
  ls_sub_unit_interface.sub_unit     ls,
  output logic [31:0]                data_out,
  output logic                       bus_req_valid,
  input  logic                       bus_req_ready,
  output logic [31:0]                bus_addr,
  output logic [31:0]                bus_wdata,
  output logic                       bus_we,
  output logic [3:0]                 bus_wstrb,
  input  logic                       bus_rvalid,
  input  logic [31:0]                bus_rdata,
  output logic                       timeout_err
);

  localparam int                      CNT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0]        MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [IO_TIMEOUT_W-1:0] TMO_LAST = IO_TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0]        pending_q, pending_d;
  logic [CNT_W-1:0]        drop_q, drop_d;
  logic [IO_TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic [31:0]             data_out_q, data_out_d;
  logic                    data_valid_q, data_valid_d;
  logic                    timeout_err_q, timeout_err_d;

  logic    hold_valid;
  io_req_t hold_req;
  io_req_t new_req;
  logic    accept;
  logic    rd_xfer;
  logic    consume;
  logic    discard;
  logic    timeout_hit;
  logic    retire;

  assign ls.ready = !hold_valid && (pending_q < MAX_CNT);
  assign accept   = ls.new_request && ls.ready;

  // A request flagged as both load and store is treated as a read
  always_comb begin
    new_req.addr  = ls_inputs.addr;
    new_req.wdata = ls_inputs.data_in;
    new_req.we    = ls_inputs.store && !ls_inputs.load;
    new_req.wstrb = ls_inputs.be;
  end

  io_req_hold u_hold (
    .clk       (clk),
    .rst       (rst),
    .load_en   (accept),
    .load_req  (new_req),
    .out_ready (bus_req_ready),
    .out_valid (hold_valid),
    .out_req   (hold_req)
  );

  assign rd_xfer     = hold_valid && bus_req_ready && !hold_req.we;
  assign discard     = bus_rvalid && (drop_q != '0);
  assign consume     = bus_rvalid && (drop_q == '0) && (pending_q != '0);
  assign timeout_hit = (pending_q != '0) && !bus_rvalid && (tmo_q == TMO_LAST);
  assign retire      = consume || timeout_hit;

  always_comb begin
    pending_d     = pending_q;
    drop_d        = drop_q;
    tmo_d         = tmo_q + IO_TIMEOUT_W'(1);
    data_out_d    = data_out_q;
    data_valid_d  = retire;
    timeout_err_d = timeout_err_q || timeout_hit;

    if (rd_xfer && !retire)      pending_d = pending_q + CNT_W'(1);
    else if (!rd_xfer && retire) pending_d = pending_q - CNT_W'(1);

    // Timed-out reads still owe a bus response; remember to swallow it
    if (discard)                               drop_d = drop_q - CNT_W'(1);
    else if (timeout_hit && drop_q != MAX_CNT) drop_d = drop_q + CNT_W'(1);

    if (pending_q == '0 || consume || discard || timeout_hit) tmo_d = '0;

    if (consume)          data_out_d = bus_rdata;
    else if (timeout_hit) data_out_d = ERR_DATA;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q     <= '0;
      drop_q        <= '0;
      tmo_q         <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      drop_q        <= drop_d;
      tmo_q         <= tmo_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign ls.data_valid = data_valid_q;
  assign data_out      = data_out_q;
  assign timeout_err   = timeout_err_q;
  assign bus_req_valid = hold_valid;
  assign bus_addr      = hold_req.addr;
  assign bus_wdata     = hold_req.wdata;
  assign bus_we        = hold_req.we;
  assign bus_wstrb     = hold_req.wstrb;

endmodule

// File: doc/io_bridge.md
# io_bridge

Load/store sub-unit that connects the core's load/store unit to the memory-mapped IO bus. It is a parametrised successor to the single-cycle IO sub-unit. It adds:
- a one-entry request holding register, so the bus can apply back-pressure;
- support for several in-order outstanding reads;
- posted writes;
- a per-read response timeout that returns error data and raises a sticky error flag.

It sits beside the data cache and local-memory sub-units under the load/store unit.

## Interface
Parameters:
- MAX_OUTSTANDING, default 2: maximum number of reads issued to the bus and not yet answered (1..8).
- TIMEOUT_CYCLES, default 255: number of cycles the head read may wait for rvalid before it is answered with error data (1..65535).
- ERR_DATA, default 32'hDEAD_BEEF: data returned for a timed-out read.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ls_inputs  in  data_access_shared_inputs_t  addr, data_in, be, store, load
- ls  ls_sub_unit_interface.sub_unit  ready (out), new_request (in), data_valid (out)
- data_out  out  32  load result, valid while ls.data_valid is high
- bus_req_valid  out  1  request present on the bus
- bus_req_ready  in  1  bus accepts the request
- bus_addr  out  32  request address
- bus_wdata  out  32  write data
- bus_we  out  1  1 = write, 0 = read
- bus_wstrb  out  4  byte enables
- bus_rvalid  in  1  read response present
- bus_rdata  in  32  read response data
- timeout_err  out  1  sticky flag: at least one read has timed out

## Operation
- The holding register (hold_valid, plus addr/wdata/we/wstrb) drives the bus_* request signals directly. bus_req_valid = hold_valid.
- ls.ready = !hold_valid && (pending < MAX_OUTSTANDING).
- On ls.new_request (legal only while ls.ready is high), the register captures ls_inputs and hold_valid is set. If ls.new_request arrives while ls.ready is low, it is ignored.
- Bus handshake: a request transfers in the cycle where bus_req_valid && bus_req_ready. hold_valid clears on that edge.
- A read that transfers increments pending. A write that transfers does not: writes are posted and produce no ls.data_valid.
- Responses return in order. On bus_rvalid:
  - if drop > 0, the response is discarded and drop decrements;
  - otherwise, when pending > 0, data_out <= bus_rdata, ls.data_valid pulses for one cycle, and pending decrements.
  - bus_rvalid with pending == 0 and drop == 0 is ignored.
- Timeout counter:
  - Clears when pending == 0 and whenever any response is consumed or discarded.
  - Otherwise increments each cycle.
  - When it reaches TIMEOUT_CYCLES-1 with no bus_rvalid in that cycle: data_out <= ERR_DATA, ls.data_valid pulses, pending decrements, drop increments, timeout_err is set, and the counter clears.
- Simultaneous events:
  - A read transfer and a consumed response in the same cycle leave pending unchanged.
  - bus_rvalid in the timeout cycle wins; no timeout is taken.
  - A timeout and a new read transfer in the same cycle leave pending unchanged and increment drop.
- Widths: pending and drop are $clog2(MAX_OUTSTANDING+1) bits. drop saturates at MAX_OUTSTANDING. The timeout counter is 16 bits.
- timeout_err clears only on rst.

## Timing
- Reset values: hold_valid, pending, drop, the timeout counter, ls.data_valid and timeout_err are 0. data_out, bus_addr, bus_wdata, bus_wstrb and bus_we are 0.
- Request path: ls.new_request in cycle N → bus_req_valid high from cycle N+1. With bus_req_ready held high, ls.ready is high again in N+2.
- Response path: bus_rvalid in cycle M → ls.data_valid and data_out valid in M+1. Latency is one registered stage.
- Back-to-back throughput with an always-ready bus: one request every 2 cycles.
- bus_req_valid must remain high, with stable request fields, until bus_req_ready is seen.
- Reset mid-operation: all state is dropped in the reset cycle. Responses arriving after reset are ignored because pending == 0.

## Structure
- Package io_bridge_pkg holds:
  - IO_TIMEOUT_W = 16;
  - the default ERR_DATA constant;
  - the typedef io_req_t {addr, wdata, we, wstrb}.
- The holding register is one natural sub-module: io_req_hold, a single-entry valid/ready register of io_req_t.
- Counters and the timeout logic stay in io_bridge.

## Test plan
- Read, bus always ready, bus_rvalid with rdata 32'h1234_5678 two cycles after the transfer → ls.data_valid one cycle later with data_out = 32'h1234_5678, and pending returns to 0.
- Write of 32'hA5A5_0000 with be = 4'b1100, bus_req_ready held low 3 cycles → fields stable, bus_we = 1, bus_wstrb = 4'b1100, ls.ready low throughout, and no ls.data_valid.
- Two reads issued with MAX_OUTSTANDING = 2 → ls.ready low until the first response. Responses 32'h1 then 32'h2 appear on data_out in order.
- Read with no response, TIMEOUT_CYCLES = 8 → data_out = 32'hDEAD_BEEF with ls.data_valid, and timeout_err = 1. A late bus_rvalid is then dropped (no ls.data_valid).
- bus_rvalid in exactly the timeout cycle → real data returned, timeout_err stays 0.
- rst asserted while one read is outstanding → all outputs zero next cycle, and a subsequent bus_rvalid produces no ls.data_valid.
